// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative signed multiply / restoring divide owning HI/LO,
// with a stall interlock for HI/LO-class instructions while an operation runs.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} stateT;
  stateT state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] opA, accHi, accLo, magRs, magRt, quoSigned, remSigned;
  logic signA, signB, isDiv, divZero;
  logic isMult, isDivOp, isMfhi, isMflo, hiLoClass, accept, divGe;
  logic [WIDTH:0] mulSum, divShift;
  logic [2*WIDTH-1:0] prod, prodSigned;
  assign isMult = funct == 6'b011000;
  assign isDivOp = funct == 6'b011010;
  assign isMfhi = funct == 6'b010000;
  assign isMflo = funct == 6'b010010;
  assign hiLoClass = isMult || isDivOp || isMfhi || isMflo;
  assign busy = state != IDLE;
  assign stall = issue && hiLoClass && busy;
  assign accept = issue && hiLoClass && !busy;
  assign magRs = rs_val[WIDTH-1] ? -rs_val : rs_val;
  assign magRt = rt_val[WIDTH-1] ? -rt_val : rt_val;
  // accHi/accLo hold {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  assign mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, opA} : '0);
  assign divShift = {accHi, accLo[WIDTH-1]};
  assign divGe = divShift >= {1'b0, opA};
  assign prod = {accHi, accLo};
  assign prodSigned = (signA ^ signB) ? -prod : prod;
  assign quoSigned = (signA ^ signB) ? -accLo : accLo;
  assign remSigned = signA ? -accHi : accHi;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      opA <= '0;
      accHi <= '0;
      accLo <= '0;
      signA <= 1'b0;
      signB <= 1'b0;
      isDiv <= 1'b0;
      divZero <= 1'b0;
      hi <= '0;
      lo <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      rd_valid <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (isMfhi || isMflo) begin
            rd_data <= isMfhi ? hi : lo;
            rd_valid <= 1'b1;
          end else begin
            signA <= rs_val[WIDTH-1];
            signB <= rt_val[WIDTH-1];
            isDiv <= isDivOp;
            divZero <= rt_val == '0;
            opA <= isDivOp ? magRt : magRs;
            accHi <= '0;
            accLo <= isDivOp ? magRs : magRt;
            cnt <= '0;
            state <= isDivOp ? DIV : MUL;
          end
        end
        MUL: begin
          {accHi, accLo} <= {mulSum, accLo[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        DIV: begin
          accHi <= divGe ? divShift[WIDTH-1:0] - opA : divShift[WIDTH-1:0];
          accLo <= {accLo[WIDTH-2:0], divGe};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          // a zero divisor leaves the dividend magnitude in the remainder, so remSigned restores rs_val
          if (isDiv) begin
            lo <= divZero ? '1 : quoSigned;
            hi <= remSigned;
            div_by_zero <= divZero;
          end else {hi, lo} <= prodSigned;
          done <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle sequencer for the HI/LO multiply/divide resource of the 32-bit MIPS core. It accepts mult, div, mfhi and mflo issued by decode. It runs an iterative signed shift-add multiply or restoring divide over WIDTH cycles and owns the HI/LO registers. It raises a stall interlock so the pipeline holds any HI/LO-class instruction while an operation is in flight.

Parameters:
WIDTH, 32, operand width; the iteration count equals WIDTH; must be even and at least 4.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
issue  input  1  decode presents a valid instruction this cycle
funct  input  6  function field: 011000 mult, 011010 div, 010000 mfhi, 010010 mflo; any other value is not HI/LO-class
rs_val  input  WIDTH  operand A (multiplicand or dividend)
rt_val  input  WIDTH  operand B (multiplier or divisor)
stall  output  1  combinational: issue is high, funct is HI/LO-class, and busy is high
busy  output  1  operation in flight
done  output  1  one-cycle pulse after HI/LO commit
rd_valid  output  1  one-cycle pulse: rd_data holds the mfhi/mflo result
rd_data  output  WIDTH  registered HI or LO value
div_by_zero  output  1  one-cycle pulse, coincident with done, for a div with rt_val equal to 0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset values: hi=0, lo=0, rd_data=0; busy, done, rd_valid, div_by_zero all 0; state IDLE; iteration counter 0.
- States: IDLE, MUL, DIV, FIX.
- busy is high whenever state is not IDLE.
- Acceptance:
  - An instruction is accepted at a clock edge when issue=1, state is IDLE, and funct is HI/LO-class.
  - A non-HI/LO-class funct is ignored and never stalls.
- mult/div accept:
  - Latch the magnitudes of rs_val and rt_val, their sign bits, and the op.
  - Clear the counter.
  - Go to MUL or DIV.
- MUL: one shift-add step per cycle on the unsigned magnitudes, producing a 2*WIDTH product. After WIDTH steps, go to FIX.
- DIV: one restoring step per cycle, giving an unsigned quotient and remainder. After WIDTH steps, go to FIX.
- FIX (1 cycle): apply signs, write hi/lo, return to IDLE. done and div_by_zero are registered and visible in the cycle after the FIX edge.
  - mult: {hi,lo} = two's-complement signed 2*WIDTH product.
  - div: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
  - Div by zero: still takes the full WIDTH+1 cycles. Result is lo = all ones, hi = rs_val; div_by_zero pulses.
  - Overflow case (most-negative / -1): lo = 0x80000000 and hi = 0 at WIDTH=32; no flag.
- Latency: busy is high for exactly WIDTH+1 cycles after the accept edge. done is high in cycle WIDTH+1 counting from 0 at the accept edge (cycle 33 for WIDTH=32). hi/lo change only at the FIX edge.
- mfhi/mflo accepted in IDLE: at that edge rd_data <= hi or lo and rd_valid pulses for 1 cycle. State stays IDLE.
- Interlock:
  - Any HI/LO-class issue while busy raises stall in the same cycle and is not accepted. Decode holds issue, funct and operands stable.
  - The instruction is accepted on the first edge where busy=0.
  - During the FIX cycle busy is still 1, so an issue there stalls. It is accepted at the next edge and sees the newly committed hi/lo.
- Reset mid-operation: abort immediately; all state returns to reset values and no done pulse is produced.
- Operands are sampled only at acceptance; later changes to rs_val/rt_val have no effect.

Test Plan:
- Reset, then mult rs=7 rt=0xFFFFFFFD (-3) -> busy for 33 cycles, done in cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- mult 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000; then div 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div 5 / 0 -> after 33 cycles lo=0xFFFFFFFF, hi=5, div_by_zero and done pulse together; div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, no flag.
- mult 100 x 3 followed immediately by mflo held on issue -> stall high until busy falls, including the FIX cycle; rd_valid then pulses once with rd_data=300; no mfhi/mflo result is produced early.
- Non-HI/LO funct (100000) issued while busy -> stall=0, no state change; mfhi while idle -> rd_valid the next cycle with rd_data=hi.
- Start mult 9 x 9, assert reset at cycle 10 -> hi=lo=0, busy=0, no done; new mult 2 x 3 then completes normally with lo=6.
